// File: rtl/condlogic_pkg.sv
// condlogic_pkg: shared condition codes and NZCV flag/group bit positions
package condlogic_pkg;
    typedef enum logic [3:0] {EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV} cond_e;
    localparam int FN = 3;
    localparam int FZ = 2;
    localparam int FC = 1;
    localparam int FV = 0;
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition check against an NZCV flag set
module cond_eval
    import condlogic_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx,
    output logic       Illegal
);
    logic n, z, c, v;
    assign n = Flags[FN];
    assign z = Flags[FZ];
    assign c = Flags[FC];
    assign v = Flags[FV];
    assign Illegal = Cond == NV;
    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            EQ: CondEx = z;
            NE: CondEx = ~z;
            CS: CondEx = c;
            CC: CondEx = ~c;
            MI: CondEx = n;
            PL: CondEx = ~n;
            VS: CondEx = v;
            VC: CondEx = ~v;
            HI: CondEx = c & ~z;
            LS: CondEx = ~(c & ~z);
            GE: CondEx = n == v;
            LT: CondEx = n != v;
            GT: CondEx = ~z & (n == v);
            LE: CondEx = ~(~z & (n == v));
            AL: CondEx = 1'b1;
            NV: CondEx = 1'b0;
        endcase
    end
endmodule

// File: rtl/condlogic_mt.sv
// condlogic_mt: multi-context condition unit with per-context NZCV flags and a 1-deep output register
module condlogic_mt
    import condlogic_pkg::*;
#(
    parameter int NCTX = 4,
    parameter int CNTW = 16,
    localparam int CW = $clog2(NCTX)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW-1:0]   in_ctx,
    input  logic [3:0]      Cond,
    input  logic [3:0]      ALUFlags,
    input  logic [1:0]      FlagW,
    input  logic            PCS,
    input  logic            RegW,
    input  logic            MemW,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            PCSrc,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            CondEx,
    output logic            Illegal,
    output logic [CW-1:0]   out_ctx,
    input  logic            fl_wr,
    input  logic [CW-1:0]   fl_wr_ctx,
    input  logic [3:0]      fl_wr_data,
    input  logic [CW-1:0]   fl_rd_ctx,
    output logic [3:0]      fl_rd_data,
    output logic [CNTW-1:0] squash_cnt,
    input  logic            cnt_clr
);
    logic [3:0] flags [NCTX];
    logic [3:0] cur;
    logic ce, il, acc;
    assign in_ready = ~out_valid | out_ready;
    assign acc = in_valid & in_ready;
    // loop-based lookup so out-of-range context indices read as zero without indexing past the array
    always_comb begin
        cur = '0;
        fl_rd_data = '0;
        for (int i = 0; i < NCTX; i++) begin
            cur = in_ctx == CW'(i) ? flags[i] : cur;
            fl_rd_data = fl_rd_ctx == CW'(i) ? flags[i] : fl_rd_data;
        end
    end
    cond_eval u_eval (
        .Cond(Cond),
        .Flags(cur),
        .CondEx(ce),
        .Illegal(il)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NCTX; i++) flags[i] <= '0;
            out_valid <= 1'b0;
            PCSrc <= 1'b0;
            RegWrite <= 1'b0;
            MemWrite <= 1'b0;
            CondEx <= 1'b0;
            Illegal <= 1'b0;
            out_ctx <= '0;
            squash_cnt <= '0;
        end else begin
            for (int i = 0; i < NCTX; i++) begin
                if (fl_wr && fl_wr_ctx == CW'(i)) flags[i] <= fl_wr_data;
                else if (acc && in_ctx == CW'(i)) begin
                    if (FlagW[FW_NZ] && ce) flags[i][FN:FZ] <= ALUFlags[FN:FZ];
                    if (FlagW[FW_CV] && ce) flags[i][FC:FV] <= ALUFlags[FC:FV];
                end
            end
            if (acc) begin
                out_valid <= 1'b1;
                PCSrc <= PCS & ce;
                RegWrite <= RegW & ce;
                MemWrite <= MemW & ce;
                CondEx <= ce;
                Illegal <= il;
                out_ctx <= in_ctx;
            end else if (out_ready) out_valid <= 1'b0;
            if (cnt_clr) squash_cnt <= '0;
            else if (acc && !ce && squash_cnt != '1) squash_cnt <= squash_cnt + CNTW'(1);
        end
    end
endmodule
